// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam int unsigned BASE_ADDR_DEF = 1024;
    localparam int          SRAM_DW       = 16;
endpackage

// File: rtl/mem_sram_ctrl_access_timer.sv
// Loadable down-counter that times one SRAM half-word access (WAIT_CYCLES+1 cycles).
module access_timer #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done,
    output logic last_next
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WAIT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // done marks the final cycle of a half; last_next means the next cycle will be final
    assign done      = (cnt == '0);
    assign last_next = (cnt == CW'(1));
endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: 32-bit loads/stores as two half-word accesses
// on a 16-bit asynchronous SRAM, freezing the pipeline via ready while busy.
//
//   state | meaning
//   IDLE  | no access; a request here is captured and the pipeline frozen
//   LO    | low half-word access ({idx,0}, bits 15:0)
//   HI    | high half-word access ({idx,1}, bits 31:16)
//   DONE  | access complete; single ready-high cycle, never starts a request
module mem_sram_ctrl
    import mem_pkg::*;
#(
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 1,
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        st_val,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);
    localparam logic [31:0] BASE  = 32'(BASE_ADDR);
    localparam logic        MULTI = (WAIT_CYCLES != 0);

    state_t               state;
    logic                 op_wr;
    logic [SRAM_DW-1:0]   st_hi;
    logic [SRAM_AW-2:0]   idx;
    logic                 req;
    logic                 tm_load;
    logic                 tm_done;
    logic                 tm_last_next;

    assign req     = rd_en | wr_en;
    assign idx     = (SRAM_AW-1)'((alu_result - BASE) >> 2);
    assign tm_load = ((state == IDLE) && req) || ((state == LO) && tm_done);
    assign ready   = ((state == IDLE) && !req) || (state == DONE);

    access_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tm_load),
        .done      (tm_done),
        .last_next (tm_last_next)
    );

    // Write strobe is released one cycle before each half ends so data is held past we_n rising.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_wr       <= 1'b0;
            st_hi       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state       <= LO;
                        op_wr       <= wr_en;
                        st_hi       <= st_val[31:16];
                        sram_addr   <= {idx, 1'b0};
                        sram_dq_out <= st_val[15:0];
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~(wr_en & MULTI);
                    end
                end
                LO: begin
                    if (tm_done) begin
                        state        <= HI;
                        sram_addr[0] <= 1'b1;
                        sram_dq_out  <= st_hi;
                        sram_we_n    <= ~(op_wr & MULTI);
                        if (!op_wr) read_data[15:0] <= sram_dq_in;
                    end else begin
                        sram_we_n <= ~(op_wr & ~tm_last_next);
                    end
                end
                HI: begin
                    if (tm_done) begin
                        state      <= DONE;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (!op_wr) read_data[31:16] <= sram_dq_in;
                    end else begin
                        sram_we_n <= ~(op_wr & ~tm_last_next);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a small 16-entry SRAM model on the main instance.
module tb_mem_sram_ctrl;
    logic        clk;
    logic        rst_n;
    logic        rd_en, wr_en;
    logic [31:0] alu_result, st_val;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe, we_n;

    logic        rd_w0, rd_w3, zero_bit;
    logic [15:0] zero_dq;
    logic [31:0] rdata_w0, rdata_w3;
    logic        rdy_w0, rdy_w3;
    logic [17:0] addr_w0, addr_w3;
    logic [15:0] dqo_w0, dqo_w3;
    logic        oe_w0, oe_w3, wen_w0, wen_w3;

    logic [15:0] mem [16] = '{default: 16'h0};

    int checks   = 0;
    int failures = 0;

    mem_sram_ctrl #(.SRAM_AW(18), .WAIT_CYCLES(1), .BASE_ADDR(1024)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
        .alu_result(alu_result), .st_val(st_val), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_in(dq_in),
        .sram_dq_oe(dq_oe), .sram_we_n(we_n)
    );

    mem_sram_ctrl #(.SRAM_AW(18), .WAIT_CYCLES(0), .BASE_ADDR(1024)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_w0), .wr_en(zero_bit),
        .alu_result(alu_result), .st_val(st_val), .read_data(rdata_w0), .ready(rdy_w0),
        .sram_addr(addr_w0), .sram_dq_out(dqo_w0), .sram_dq_in(zero_dq),
        .sram_dq_oe(oe_w0), .sram_we_n(wen_w0)
    );

    mem_sram_ctrl #(.SRAM_AW(18), .WAIT_CYCLES(3), .BASE_ADDR(1024)) dut_w3 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_w3), .wr_en(zero_bit),
        .alu_result(alu_result), .st_val(st_val), .read_data(rdata_w3), .ready(rdy_w3),
        .sram_addr(addr_w3), .sram_dq_out(dqo_w3), .sram_dq_in(zero_dq),
        .sram_dq_oe(oe_w3), .sram_we_n(wen_w3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dq_in = mem[sram_addr[3:0]];

    always @(posedge clk) begin
        if (dq_oe && !we_n) mem[sram_addr[3:0]] <= dq_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request and watches it until ready returns high (bounded).
    task automatic run_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit keep, output int lows, output logic [17:0] alo,
                          output logic [17:0] ahi, output int we_lows, output int oe_cnt);
        rd_en = r; wr_en = w; alu_result = a; st_val = d;
        lows = 0; we_lows = 0; oe_cnt = 0; alo = '0; ahi = '0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (ready) break;
            lows++;
            if (lows == 2) alo = sram_addr;
            ahi = sram_addr;
            if (!we_n) we_lows++;
            if (dq_oe) oe_cnt++;
            @(negedge clk); #1;
        end
        if (!keep) begin
            rd_en = 1'b0; wr_en = 1'b0;
        end
    endtask

    task automatic sweep(input int w, output int lows);
        if (w == 0) rd_w0 = 1'b1; else rd_w3 = 1'b1;
        #1;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if ((w == 0) ? rdy_w0 : rdy_w3) break;
            lows++;
            @(negedge clk); #1;
        end
        rd_w0 = 1'b0; rd_w3 = 1'b0;
    endtask

    initial begin
        int          lows, we_lows, oe_cnt, rises;
        logic [17:0] alo, ahi;
        logic        prev;

        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; alu_result = '0; st_val = '0;
        rd_w0 = 1'b0; rd_w3 = 1'b0; zero_bit = 1'b0; zero_dq = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_we_n", {31'b0, we_n}, 32'd1);
        chk("rst_oe", {31'b0, dq_oe}, 32'd0);
        chk("rst_addr", {14'b0, sram_addr}, 32'd0);
        chk("rst_dq_out", {16'b0, dq_out}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // store then load at 1028
        @(negedge clk);
        run_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, lows, alo, ahi, we_lows, oe_cnt);
        chk("st_lows", lows, 32'd5);
        chk("st_addr_lo", {14'b0, alo}, 32'd2);
        chk("st_addr_hi", {14'b0, ahi}, 32'd3);
        chk("st_we_lows", we_lows, 32'd2);
        chk("st_oe_cnt", oe_cnt, 32'd4);
        chk("st_mem2", {16'b0, mem[2]}, 32'h0000BEEF);
        chk("st_mem3", {16'b0, mem[3]}, 32'h0000DEAD);
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, lows, alo, ahi, we_lows, oe_cnt);
        chk("ld_lows", lows, 32'd5);
        chk("ld_we_lows", we_lows, 32'd0);
        chk("ld_oe_cnt", oe_cnt, 32'd0);
        chk("ld_data", read_data, 32'hDEADBEEF);

        // rd and wr together: write wins
        @(negedge clk);
        run_op(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, lows, alo, ahi, we_lows, oe_cnt);
        chk("both_addr_lo", {14'b0, alo}, 32'd0);
        chk("both_addr_hi", {14'b0, ahi}, 32'd1);
        chk("both_mem0", {16'b0, mem[0]}, 32'h00005678);
        chk("both_mem1", {16'b0, mem[1]}, 32'h00001234);
        chk("both_read_data", read_data, 32'hDEADBEEF);

        // address wrap
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'd525312, 32'h0, 1'b0, lows, alo, ahi, we_lows, oe_cnt);
        chk("wrap_addr_lo", {14'b0, alo}, 32'd0);
        chk("wrap_addr_hi", {14'b0, ahi}, 32'd1);
        chk("wrap_data", read_data, 32'h12345678);
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0, lows, alo, ahi, we_lows, oe_cnt);
        chk("under_addr_lo", {14'b0, alo}, 32'h3FFFE);
        chk("under_addr_hi", {14'b0, ahi}, 32'h3FFFF);
        chk("under_data", read_data, 32'h0);

        // request withdrawn during LO
        @(negedge clk); rd_en = 1'b1; alu_result = 32'd1024;
        @(negedge clk); rd_en = 1'b0; alu_result = 32'd0;
        #1;
        chk("chg_ready_lo", {31'b0, ready}, 32'd0);
        prev = ready; rises = 0; lows = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (ready && !prev) rises++;
            if (!ready) lows++;
            prev = ready;
        end
        chk("chg_pulses", rises, 32'd1);
        chk("chg_lows", lows, 32'd3);
        chk("chg_data", read_data, 32'h12345678);
        chk("chg_addr_hold", {14'b0, sram_addr}, 32'd1);

        // back-to-back loads
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, lows, alo, ahi, we_lows, oe_cnt);
        chk("b2b_lows1", lows, 32'd5);
        chk("b2b_data1", read_data, 32'hDEADBEEF);
        alu_result = 32'd1024;
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, lows, alo, ahi, we_lows, oe_cnt);
        chk("b2b_lows2", lows, 32'd5);
        chk("b2b_data2", read_data, 32'h12345678);

        // reset in the middle of a write's high half
        @(negedge clk); wr_en = 1'b1; alu_result = 32'd1028; st_val = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_we_n", {31'b0, we_n}, 32'd0);
        chk("mid_addr", {14'b0, sram_addr}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("async_we_n", {31'b0, we_n}, 32'd1);
        chk("async_oe", {31'b0, dq_oe}, 32'd0);
        chk("async_read_data", read_data, 32'h0);
        chk("async_addr", {14'b0, sram_addr}, 32'd0);
        @(negedge clk); wr_en = 1'b0; rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, ready}, 32'd1);

        // wait-state sweep
        @(negedge clk);
        sweep(0, lows);
        chk("sweep_w0", lows, 32'd3);
        @(negedge clk);
        sweep(3, lows);
        chk("sweep_w3", lows, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
